// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared stage record, depth helper and parameter check for the pipelined adder
//
// Purpose: common definitions imported by pipelined_ripple_adder.
//   ADDER_STAGE_T(W) : stage record for a W-bit datapath
//                      (valid, partial sum, remaining a/b, slice carry-out, MSB carry-in)
//   calc_stages      : pipeline depth for a given WIDTH/CHUNK
//   chunk_ok         : legality of a WIDTH/CHUNK pair, checked at elaboration
// No ports.

`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV

// Packages cannot take parameters, so the width-dependent record is a typedef macro.
// rem_a/rem_b are kept shifted down so the next slice to add is always bits [CHUNK-1:0].
`define ADDER_STAGE_T(W) struct packed { \
   logic           valid;   \
   logic [(W)-1:0] psum;    \
   logic [(W)-1:0] rem_a;   \
   logic [(W)-1:0] rem_b;   \
   logic           carry;   \
   logic           msb_cin; \
}

package adder_pkg;

   function automatic int calc_stages(input int width, input int chunk);
      return width / chunk;
   endfunction

   function automatic bit chunk_ok(input int width, input int chunk);
      return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
   endfunction

endpackage

`endif

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational CHUNK-bit ripple of full-adder cells
//
// Ports:
//   a, b     in  CHUNK  operand slices
//   cin      in  1      carry into bit 0
//   sum      out CHUNK  slice sum
//   cout     out 1      carry out of the slice MSB
//   msb_cin  out 1      carry into the slice MSB (signed-overflow term)

module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             msb_cin
);

   logic [CHUNK:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout    = c[CHUNK];
   assign msb_cin = c[CHUNK - 1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// rtl/pipelined_ripple_adder.sv - elastic WIDTH-bit adder, one CHUNK-bit ripple slice per stage
//
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      asynchronous active-high reset
//   in_valid   in  1      operands present
//   in_ready   out 1      operands accepted this cycle
//   a, b       in  WIDTH  operands
//   cin        in  1      carry-in
//   out_valid  out 1      result present
//   out_ready  in  1      consumer takes the result
//   sum        out WIDTH  a+b+cin mod 2^WIDTH
//   cout       out 1      unsigned carry-out
//   ovf        out 1      signed overflow

module pipelined_ripple_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = calc_stages(WIDTH, CHUNK);

   if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_params
      $error("pipelined_ripple_adder: WIDTH must be a positive multiple of CHUNK");
   end

   typedef `ADDER_STAGE_T(WIDTH) stage_t;

   stage_t st  [STAGES];
   stage_t nxt [STAGES];

   // adv[k]: stage k may load this cycle; adv[STAGES] stands for the consumer.
   logic [STAGES:0] adv;

   logic [STAGES*CHUNK-1:0] cs;
   logic [STAGES-1:0]       cc;
   logic [STAGES-1:0]       cm;

   for (genvar g = 0; g < STAGES; g++) begin : g_slice
      if (g == 0) begin : g_first
         chunk_adder #(.CHUNK(CHUNK)) u_chunk (
            .a       (a[CHUNK-1:0]),
            .b       (b[CHUNK-1:0]),
            .cin     (cin),
            .sum     (cs[g*CHUNK +: CHUNK]),
            .cout    (cc[g]),
            .msb_cin (cm[g])
         );
      end else begin : g_rest
         chunk_adder #(.CHUNK(CHUNK)) u_chunk (
            .a       (st[g-1].rem_a[CHUNK-1:0]),
            .b       (st[g-1].rem_b[CHUNK-1:0]),
            .cin     (st[g-1].carry),
            .sum     (cs[g*CHUNK +: CHUNK]),
            .cout    (cc[g]),
            .msb_cin (cm[g])
         );
      end
   end

   always_comb begin
      // Ready ripples back from the consumer; a full stage moves only if its successor does.
      adv         = '0;
      adv[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         adv[k] = !st[k].valid || adv[k + 1];
      end

      for (int k = 0; k < STAGES; k++) begin
         nxt[k] = '0;
      end

      nxt[0].valid   = in_valid;
      nxt[0].psum    = WIDTH'(cs[CHUNK-1:0]);
      nxt[0].rem_a   = a >> CHUNK;
      nxt[0].rem_b   = b >> CHUNK;
      nxt[0].carry   = cc[0];
      nxt[0].msb_cin = cm[0];

      for (int k = 1; k < STAGES; k++) begin
         nxt[k].valid   = st[k-1].valid;
         nxt[k].psum    = st[k-1].psum | (WIDTH'(cs[k*CHUNK +: CHUNK]) << (k * CHUNK));
         nxt[k].rem_a   = st[k-1].rem_a >> CHUNK;
         nxt[k].rem_b   = st[k-1].rem_b >> CHUNK;
         nxt[k].carry   = cc[k];
         nxt[k].msb_cin = cm[k];
      end
   end

   // Data only loads alongside a valid entry, so the last result stays on sum/cout/ovf
   // after it drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            st[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
               if (nxt[k].valid) begin
                  st[k] <= nxt[k];
               end else begin
                  st[k].valid <= 1'b0;
               end
            end
         end
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = st[STAGES-1].valid;
   assign sum       = st[STAGES-1].psum;
   assign cout      = st[STAGES-1].carry;
   assign ovf       = st[STAGES-1].carry ^ st[STAGES-1].msb_cin;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb/tb_pipelined_ripple_adder.sv - scoreboard bench for pipelined_ripple_adder

module tb_pipelined_ripple_adder;

   localparam int WIDTH  = 16;
   localparam int CHUNK  = 4;
   localparam int STAGES = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   always #5 clk = ~clk;

   pipelined_ripple_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   typedef struct packed {
      logic [WIDTH-1:0] s;
      logic             c;
      logic             o;
   } res_t;

   res_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   pop_total = 0;
   int   pop_cyc[64];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic res_t model(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                  input logic vc);
      logic [WIDTH:0] t;
      res_t r;
      t   = {1'b0, va} + {1'b0, vb} + (WIDTH+1)'(vc);
      r.s = t[WIDTH-1:0];
      r.c = t[WIDTH];
      r.o = (va[WIDTH-1] == vb[WIDTH-1]) && (t[WIDTH-1] != va[WIDTH-1]);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor: any visible result must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 32'(out_valid), 32'd0);
         end else begin
            check("result", 32'({sum, cout, ovf}), 32'(sb[0]));
            if (out_ready) begin
               void'(sb.pop_front());
               pop_cyc[pop_total % 64] = cyc;
               pop_total++;
            end
         end
      end
   end

   // Present one operand set and hold it until accepted; pushes the expectation on accept.
   task automatic drive(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vc, output int acc_cyc);
      int waited;
      waited = 0;
      @(posedge clk);
      #1;
      a        = va;
      b        = vb;
      cin      = vc;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         waited++;
      end
      acc_cyc = cyc;
      if (in_ready) sb.push_back(model(va, vb, vc));
      else check("in_ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 300) begin
         @(negedge clk);
         w++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   // Single transaction with out_ready high: latency and literal result checks.
   task automatic run_one(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vc, input logic [WIDTH-1:0] es, input logic ec,
                          input logic eo);
      int acc;
      int w;
      drive(va, vb, vc, acc);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      w = 0;
      @(negedge clk);
      while (!out_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_latency"}, 32'(cyc - acc), 32'(STAGES));
      check({tag, "_sum"}, 32'(sum), 32'(es));
      check({tag, "_cout"}, 32'(cout), 32'(ec));
      check({tag, "_ovf"}, 32'(ovf), 32'(eo));
      @(negedge clk);
      check({tag, "_single"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int acc;
      int p0;
      int w;
      int accepted;
      int idx;
      int n_acc;
      int guard;
      logic pending;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic rc;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed single adds
      run_one("add_1_6", 16'h0001, 16'h0006, 1'b0, 16'h0007, 1'b0, 1'b0);
      run_one("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_one("sovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

      // Back-to-back stream, 32 results on consecutive cycles
      p0 = pop_total;
      for (int i = 0; i < 32; i++) begin
         drive(WIDTH'(i), WIDTH'(2 * i), i[0], acc);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      w = 0;
      while (pop_total < p0 + 32 && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("b2b_count", 32'(pop_total - p0), 32'd32);
      check("b2b_span", 32'(pop_cyc[(p0 + 31) % 64] - pop_cyc[p0 % 64]), 32'd31);

      // Back-pressure: 6 offered, only STAGES taken while out_ready is low
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      accepted  = 0;
      idx       = 0;
      for (int t = 0; t < 8; t++) begin
         if (t != 0) begin
            @(posedge clk);
            #1;
         end
         a        = WIDTH'(16'h1111 * (idx + 1));
         b        = WIDTH'(16'h0F0F + idx);
         cin      = idx[0];
         in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(model(a, b, cin));
            accepted++;
            idx++;
         end
      end
      check("bp_accepted", 32'(accepted), 32'(STAGES));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("bp_held_sum", 32'(sum), 32'(sb[0].s));
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int i = accepted; i < 6; i++) begin
         drive(WIDTH'(16'h1111 * (i + 1)), WIDTH'(16'h0F0F + i), i[0], acc);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain();

      // Random valid/ready traffic
      n_acc   = 0;
      guard   = 0;
      pending = 1'b0;
      ra = '0;
      rb = '0;
      rc = 1'b0;
      while (n_acc < 10000 && guard < 60000) begin
         @(posedge clk);
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
         if (!pending && ($urandom_range(0, 3) != 0)) begin
            ra      = WIDTH'($urandom);
            rb      = WIDTH'($urandom);
            rc      = 1'($urandom);
            pending = 1'b1;
         end
         in_valid = pending;
         a        = ra;
         b        = rb;
         cin      = rc;
         @(negedge clk);
         if (in_valid && in_ready) begin
            sb.push_back(model(ra, rb, rc));
            pending = 1'b0;
            n_acc++;
         end
         guard++;
      end
      check("rand_accepted", 32'(n_acc), 32'd10000);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      // Reset with results in flight
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(WIDTH'(16'h0100 + i), WIDTH'(16'h0A00), 1'b1, acc);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_sum", 32'(sum), 32'd0);
      check("mid_rst_cout", 32'(cout), 32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      run_one("post_rst", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      repeat (8) @(negedge clk);
      check("final_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
